e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline with exception support.
- Owns the HI/LO registers and runs multi-cycle mult/div operations.
- Produces the mfhi/mflo result that the E/M pipeline register captures as E_MD_date.
- Provides a busy indication to the hazard unit, and suppresses new operations on exception/interrupt request (Req).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range ≥ 1.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range ≥ 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- Req  input  1  exception/interrupt request from CP0; flushes the E-stage instruction.
- md_op  input  4  operation of the instruction currently in E (encoding in shared constants).
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- busy  output  1  start | (cnt != 0); the hazard unit stalls D on any md instruction while high.
- MD_date  output  32  HI if md_op == MFHI, LO if md_op == MFLO, else 0 (combinational from registers).

Behaviour:
- Reset: HI = 0, LO = 0, cnt = 0, pending result = 0.
  - busy = 0, and MD_date = 0 unless md_op is MFHI/MFLO.
  - Reset mid-operation discards the operation; no HI/LO commit.
- start = (md_op ∈ {MULT, MULTU, DIV, DIVU}) & !Req & (cnt == 0).
- Timing of a started operation:
  - On a start in cycle T, the full result is computed and latched into hi_tmp/lo_tmp at the cycle-T edge.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES at the same edge.
  - cnt decrements every cycle while nonzero.
  - On the edge where cnt goes 1→0, HI/LO ← hi_tmp/lo_tmp.
  - busy is high in cycle T and in cycles T+1..T+N; the new HI/LO is visible from cycle T+N+1.
- Arithmetic:
  - MULT: signed 32x32 → 64; HI = [63:32], LO = [31:0]. MULTU: unsigned.
  - DIV: LO = signed quotient, HI = signed remainder; truncation toward zero, remainder takes the sign of the dividend. DIVU: unsigned.
  - Divide by zero: operation still occupies DIV_CYCLES; HI/LO left unchanged at commit.
- MTHI/MTLO: HI/LO ← rs_data at the edge, when !Req and cnt == 0. Single cycle, busy stays 0.
- MFHI/MFLO: pure read, no state change.
- Req priority:
  - With Req = 1, the md_op in E is ignored: no start, no mthi/mtlo write.
  - An operation already counting (issued by an older instruction) continues and commits normally.
- Protocol: md_op ≠ NONE while cnt ≠ 0 is a hazard-unit violation. The block ignores such ops, and a checker flags them.
- Simultaneous commit and reset: reset wins.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} ← {HI,LO} + signed(rs*rt), mod 2^64.
  - MADDU: same with an unsigned product.
  - Both use the current HI/LO at start, and take MULT_CYCLES latency with the same busy/commit rules.
- Undefined: MADD/MADDU encodings are treated as NONE (no start, busy unaffected).

Decomposition:
- Shared constants header (with the existing pipeline constants) holds the md_op encodings:
  - NONE = 0, MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MFHI = 5, MFLO = 6, MTHI = 7, MTLO = 8, MADD = 9, MADDU = 10.
- Also in the header: default cycle counts.
- No sub-module needed; a single module with a counter and temp registers.

Test Plan:
- MULT rs = 0xFFFF_FFFE (-2), rt = 3 → busy high for 6 cycles (start cycle + 5); then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA; mfhi/mflo return them.
- DIV rs = -7 (0xFFFF_FFF9), rt = 2 → after 10 busy cycles: LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU on the same operands: LO = 0x7FFF_FFFC, HI = 1.
- MTHI rs = 0x1234_5678 with Req = 1 → HI unchanged. Repeated with Req = 0 → HI = 0x1234_5678 next cycle, busy never high.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF started, then reset asserted at cnt = 2 → HI = LO = 0, busy = 0, and no later commit.
- DIV by 0 with HI = 5, LO = 6 → busy 11 cycles; HI = 5, LO = 6 after.
- MDU_MADD_EN: HI = 0, LO = 0xFFFF_FFFF, MADDU 1 × 1 → HI = 1, LO = 0. Without the macro → no busy, HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_pkg
//  Description : Shared pipeline constants for the execute-stage mult/div unit.
//                Holds the md_op encodings and the default latency values.
//  Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    // md_op encodings carried down the pipeline with each instruction
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10
    } md_op_e;

    // Default busy latencies (cycles after the start cycle)
    localparam int c_MULT_CYCLES = 5;
    localparam int c_DIV_CYCLES  = 10;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_if
//  Description : E-stage <-> mult/div unit connection.
//                master : pipeline side (drives Req, md_op, operands)
//                slave  : e_mdu side (drives busy, MD_date)
//  Revision    : 1.0 - initial release
// ============================================================================
interface e_mdu_if
    import e_mdu_pkg::*;
;
    logic        Req;      // exception/interrupt flush of the E-stage instr
    md_op_e      md_op;    // operation of the instruction in E
    logic [31:0] rs_data;  // forwarded rs operand
    logic [31:0] rt_data;  // forwarded rt operand
    logic        busy;     // stall request to the hazard unit
    logic [31:0] MD_date;  // mfhi/mflo result towards the E/M register

    modport master (
        output Req, md_op, rs_data, rt_data,
        input  busy, MD_date
    );

    modport slave (
        input  Req, md_op, rs_data, rt_data,
        output busy, MD_date
    );
endinterface
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu
//  Description : Execute-stage multiply/divide unit. Owns HI/LO, runs
//                multi-cycle mult/div, provides mfhi/mflo data and busy.
//                The full result is computed in the start cycle and held in
//                temp registers; HI/LO are only updated when the counter
//                expires so the architectural latency is preserved.
//  Ports       : clk, reset (sync, active-high)
//                md  (e_mdu_if.slave) : Req, md_op, rs_data, rt_data -> busy,
//                                       MD_date
//  Config      : `define MDU_MADD_EN enables MADD/MADDU; otherwise those
//                encodings behave like NONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES,
    parameter int DIV_CYCLES  = c_DIV_CYCLES
) (
    input  wire logic clk,
    input  wire logic reset,
    e_mdu_if.slave    md
);

    localparam int CNT_W = $clog2(f_max(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_tmp;
    logic [31:0]      r_lo_tmp;
    logic             r_commit;   // 0 for divide-by-zero: HI/LO left untouched
    logic [CNT_W-1:0] r_cnt;

    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic             w_div_zero;
    logic [31:0]      w_divisor;
    logic [31:0]      w_quot_s;
    logic [31:0]      w_rem_s;
    logic [31:0]      w_quot_u;
    logic [31:0]      w_rem_u;
    logic             w_valid;
    logic [63:0]      w_res;
    logic [CNT_W-1:0] w_len;
    logic             w_ok;
    logic             w_idle;
    logic             w_start;
    logic             w_mt_en;

    assign w_prod_s = $signed({{32{md.rs_data[31]}}, md.rs_data})
                    * $signed({{32{md.rt_data[31]}}, md.rt_data});
    assign w_prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

    // Divide by a safe value on zero so the datapath never produces X;
    // the result is discarded at commit anyway.
    assign w_div_zero = (md.rt_data == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : md.rt_data;
    assign w_quot_s   = $signed(md.rs_data) / $signed(w_divisor);
    assign w_rem_s    = $signed(md.rs_data) % $signed(w_divisor);
    assign w_quot_u   = md.rs_data / w_divisor;
    assign w_rem_u    = md.rs_data % w_divisor;

    always_comb begin
        w_valid = 1'b0;
        w_res   = 64'd0;
        w_len   = '0;
        w_ok    = 1'b1;
        case (md.md_op)
            MD_MULT:  begin w_valid = 1'b1; w_res = w_prod_s; w_len = CNT_W'(MULT_CYCLES); end
            MD_MULTU: begin w_valid = 1'b1; w_res = w_prod_u; w_len = CNT_W'(MULT_CYCLES); end
            MD_DIV: begin
                w_valid = 1'b1;
                w_res   = {w_rem_s, w_quot_s};
                w_len   = CNT_W'(DIV_CYCLES);
                w_ok    = !w_div_zero;
            end
            MD_DIVU: begin
                w_valid = 1'b1;
                w_res   = {w_rem_u, w_quot_u};
                w_len   = CNT_W'(DIV_CYCLES);
                w_ok    = !w_div_zero;
            end
`ifdef MDU_MADD_EN
            MD_MADD:  begin w_valid = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; w_len = CNT_W'(MULT_CYCLES); end
            MD_MADDU: begin w_valid = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; w_len = CNT_W'(MULT_CYCLES); end
`endif
            default: ;
        endcase
    end

    // Ops arriving while counting are hazard violations and are ignored.
    assign w_idle  = (r_cnt == '0);
    assign w_start = w_valid && !md.Req && w_idle;
    assign w_mt_en = !md.Req && w_idle;
    assign md.busy = w_start || !w_idle;

    always_comb begin
        md.MD_date = 32'd0;
        if (md.md_op == MD_MFHI)      md.MD_date = r_hi;
        else if (md.md_op == MD_MFLO) md.MD_date = r_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_commit <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_start) begin
                r_hi_tmp <= w_res[63:32];
                r_lo_tmp <= w_res[31:0];
                r_commit <= w_ok;
                r_cnt    <= w_len;
            end else if (!w_idle) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1) && r_commit) begin
                    r_hi <= r_hi_tmp;
                    r_lo <= r_lo_tmp;
                end
            end
            // Only possible while idle, so never collides with a commit.
            if (w_mt_en && md.md_op == MD_MTHI) r_hi <= md.rs_data;
            if (w_mt_en && md.md_op == MD_MTLO) r_lo <= md.rs_data;
        end
    end

    // Hazard unit must hold md instructions in D while the unit is counting.
    a_no_op_while_busy : assert property (
        @(posedge clk) disable iff (reset) (r_cnt != '0) |-> (md.md_op == MD_NONE)
    );

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_mdu
//  Description : Directed self-checking bench for e_mdu. Expected values are
//                hand-computed constants. Build with +define+MDU_MADD_EN to
//                exercise the multiply-accumulate variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    e_mdu_if mdif ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read HI and LO through mfhi/mflo, and confirm NONE reads as zero.
    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        @(posedge clk); #1;
        mdif.md_op = MD_MFHI; #1;
        check({tag, "_hi"}, mdif.MD_date, eh);
        mdif.md_op = MD_MFLO; #1;
        check({tag, "_lo"}, mdif.MD_date, el);
        mdif.md_op = MD_NONE; #1;
        check({tag, "_none"}, mdif.MD_date, 32'd0);
    endtask

    // Issue one op for one cycle and count the cycles busy is high.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic req, input int exp_busy);
        int n;
        n = 0;
        @(posedge clk); #1;
        mdif.md_op = op; mdif.rs_data = a; mdif.rt_data = b; mdif.Req = req;
        @(negedge clk);
        if (mdif.busy) n++;
        @(posedge clk); #1;
        mdif.md_op = MD_NONE; mdif.Req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mdif.busy) break;
            n++;
        end
        check({tag, "_busy"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        mdif.Req = 1'b0; mdif.md_op = MD_NONE; mdif.rs_data = '0; mdif.rt_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_busy", 32'(mdif.busy), 32'd0);
        read_hilo("rst", 32'd0, 32'd0);

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 6);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 11);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 11);
        read_hilo("divu", 32'd1, 32'h7FFF_FFFC);

        run_op("mthi_req", MD_MTHI, 32'h1234_5678, 32'd0, 1'b1, 0);
        read_hilo("mthi_req", 32'd1, 32'h7FFF_FFFC);
        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 0);
        read_hilo("mthi", 32'h1234_5678, 32'h7FFF_FFFC);
        run_op("mtlo", MD_MTLO, 32'hCAFE_BABE, 32'd0, 1'b0, 0);
        read_hilo("mtlo", 32'h1234_5678, 32'hCAFE_BABE);

        run_op("multu_req", MD_MULTU, 32'd7, 32'd7, 1'b1, 0);
        read_hilo("multu_req", 32'h1234_5678, 32'hCAFE_BABE);

        // Req raised while an older op is counting must not cancel it.
        @(posedge clk); #1;
        mdif.md_op = MD_MULTU; mdif.rs_data = 32'd2; mdif.rt_data = 32'd3;
        @(posedge clk); #1;
        mdif.md_op = MD_NONE; mdif.Req = 1'b1;
        @(posedge clk); #1;
        mdif.Req = 1'b0;
        repeat (5) @(posedge clk);
        read_hilo("req_cont", 32'd0, 32'd6);

        // Reset while cnt == 2 discards the pending multu.
        @(posedge clk); #1;
        mdif.md_op = MD_MULTU; mdif.rs_data = 32'hFFFF_FFFF; mdif.rt_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;          // cnt = 5
        mdif.md_op = MD_NONE;
        repeat (3) @(posedge clk);   // cnt = 2
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(mdif.busy), 32'd0);
        repeat (8) @(posedge clk);
        check("rstmid_busy_late", 32'(mdif.busy), 32'd0);
        read_hilo("rstmid", 32'd0, 32'd0);

        run_op("set_hi5", MD_MTHI, 32'd5, 32'd0, 1'b0, 0);
        run_op("set_lo6", MD_MTLO, 32'd6, 32'd0, 1'b0, 0);
        run_op("div0", MD_DIV, 32'd100, 32'd0, 1'b0, 11);
        read_hilo("div0", 32'd5, 32'd6);

        run_op("clr_hi", MD_MTHI, 32'd0, 32'd0, 1'b0, 0);
        run_op("set_lo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
`ifdef MDU_MADD_EN
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 1'b0, 6);
        read_hilo("maddu", 32'd1, 32'd0);
        run_op("madd", MD_MADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 6);
        read_hilo("madd", 32'd0, 32'hFFFF_FFFF);
`else
        run_op("maddu_off", MD_MADDU, 32'd1, 32'd1, 1'b0, 0);
        read_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
